// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths and constants for the register file writeback arbiter.
package wb_write_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage : wb_write_arbiter_pkg

// File: rtl/wb_pending_fifo.sv
// Small circular FIFO holding mult/div results until the write port is free.
// Exposes per-entry valid/reg vectors so hazard logic can see pending targets.
module wb_pending_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clock,
    input  logic                                ctrl_reset,
    input  logic                                push,
    input  logic [REG_IDX_W-1:0]                push_reg,
    input  logic [DATA_W-1:0]                   push_data,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output logic [REG_IDX_W-1:0]                head_reg,
    output logic [DATA_W-1:0]                   head_data,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]     entry_reg
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [REG_IDX_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0]    mem_data [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_reg  = mem_reg[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are qualified by entry_valid, so no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr]  <= push_reg;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        entry_reg   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
            entry_reg[i]   = mem_reg[i];
        end
    end

endmodule : wb_pending_fifo

// File: rtl/wb_write_arbiter.sv
// Merges pipeline writeback with buffered mult/div results onto the single
// register file write port. Pipeline always wins; mult/div waits in a FIFO.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clock,
    input  logic                 ctrl_reset,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 md_valid,
    output logic                 md_ready,
    input  logic [REG_IDX_W-1:0] md_reg,
    input  logic [DATA_W-1:0]    md_data,
    input  logic [REG_IDX_W-1:0] query_reg,
    output logic                 query_pending,
    output logic                 wb_stall,
    output logic                 ctrl_writeEnable,
    output logic [REG_IDX_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]    data_writeReg
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                            wb_sel_p0;
    logic                            md_push_p0;
    logic                            md_pop_p0;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [REG_IDX_W-1:0]            head_reg;
    logic [DATA_W-1:0]               head_data;
    logic [DEPTH-1:0]                entry_valid;
    logic [DEPTH-1:0][REG_IDX_W-1:0] entry_reg;
    logic [SW-1:0]                   starve_cnt;

    // A zero destination is not a request: pipeline $0 lets the FIFO drain,
    // and a mult/div $0 result completes its handshake but is never stored.
    assign wb_sel_p0  = wb_valid && (wb_reg != REG_ZERO);
    assign md_ready   = !fifo_full;
    assign md_push_p0 = md_valid && md_ready && (md_reg != REG_ZERO);
    assign md_pop_p0  = !wb_sel_p0 && !fifo_empty;
    assign wb_stall   = (starve_cnt == SW'(STARVE_MAX));

    wb_pending_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .push        (md_push_p0),
        .push_reg    (md_reg),
        .push_data   (md_data),
        .pop         (md_pop_p0),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_reg    (head_reg),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_reg   (entry_reg)
    );

    // ---- stage p0 -> p1: registered write port; reg/data hold when idle ----
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= REG_ZERO;
            data_writeReg    <= '0;
        end else begin
            ctrl_writeEnable <= wb_sel_p0 || md_pop_p0;
            if (wb_sel_p0) begin
                ctrl_writeReg <= wb_reg;
                data_writeReg <= wb_data;
            end else if (md_pop_p0) begin
                ctrl_writeReg <= head_reg;
                data_writeReg <= head_data;
            end
        end
    end

    // Count consecutive cycles the FIFO head loses to the pipeline, saturating.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || md_pop_p0) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Hazard probe: any live FIFO entry or the uncommitted output stage.
    always_comb begin
        query_pending = 1'b0;
        if (query_reg != REG_ZERO) begin
            if (ctrl_writeEnable && (ctrl_writeReg == query_reg)) begin
                query_pending = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_valid[i] && (entry_reg[i] == query_reg)) begin
                    query_pending = 1'b1;
                end
            end
        end
    end

endmodule : wb_write_arbiter

// File: tb/tb_wb_write_arbiter.sv
// Directed and randomized stimulus against a queue-based reference model.
module tb_wb_write_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic [4:0]  query_reg;
    logic        query_pending;
    logic        wb_stall;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_starve;

    wb_write_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .query_reg        (query_reg),
        .query_pending    (query_pending),
        .wb_stall         (wb_stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en     = 1'b0;
        m_reg    = 5'd0;
        m_data   = 32'd0;
        m_starve = 0;
    endtask

    // One clock cycle: drive at negedge, compare outputs against the model,
    // then advance the model to what the upcoming rising edge should produce.
    task automatic cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] qr);
        logic exp_qp;
        logic sel_wb;
        logic popped;
        logic accept;
        int   sz;
        ent_t head;
        @(negedge clock);
        wb_valid  = wv;
        wb_reg    = wr;
        wb_data   = wd;
        md_valid  = mv;
        md_reg    = mr;
        md_data   = md;
        query_reg = qr;
        #1;
        exp_qp = 1'b0;
        if (qr != 5'd0) begin
            if (m_en && m_reg == qr) exp_qp = 1'b1;
            foreach (q[i]) if (q[i].r == qr) exp_qp = 1'b1;
        end
        chk("md_ready", {31'd0, md_ready}, {31'd0, (q.size() < DEPTH)});
        chk("wb_stall", {31'd0, wb_stall}, {31'd0, (m_starve == STARVE_MAX)});
        chk("query_pending", {31'd0, query_pending}, {31'd0, exp_qp});
        chk("write_enable", {31'd0, ctrl_writeEnable}, {31'd0, m_en});
        chk("write_reg", {27'd0, ctrl_writeReg}, {27'd0, m_reg});
        chk("write_data", data_writeReg, m_data);

        sz     = q.size();
        sel_wb = wv && (wr != 5'd0);
        popped = !sel_wb && (sz > 0);
        accept = mv && (sz < DEPTH);
        if (sel_wb) begin
            m_en = 1'b1; m_reg = wr; m_data = wd;
        end else if (popped) begin
            head = q.pop_front();
            m_en = 1'b1; m_reg = head.r; m_data = head.d;
        end else begin
            m_en = 1'b0;
        end
        if (popped || sz == 0) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (accept && mr != 5'd0) q.push_back('{r: mr, d: md});
    endtask

    task automatic idle(input logic [4:0] qr);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qr);
    endtask

    // Let the pending edge happen and settle before explicit port checks.
    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
        query_reg = 5'd0;
        model_reset();
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b0;
        #1;
        chk("rst_en", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("rst_reg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("rst_data", data_writeReg, 32'd0);
        chk("rst_ready", {31'd0, md_ready}, 32'd1);
        chk("rst_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_qp", {31'd0, query_pending}, 32'd0);

        // Pipeline only, then a $0 pipeline request produces no write.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0);
        after_edge();
        chk("pipe_en", {31'd0, ctrl_writeEnable}, 32'd1);
        chk("pipe_reg", {27'd0, ctrl_writeReg}, 32'd5);
        chk("pipe_data", data_writeReg, 32'hDEADBEEF);
        cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0);
        after_edge();
        chk("pipe_r0_en", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("pipe_r0_hold", {27'd0, ctrl_writeReg}, 32'd5);

        // Fill the FIFO behind pipeline traffic, then drain in order.
        cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h12, 5'd0);
        cycle(1'b1, 5'd4, 32'h4, 1'b1, 5'd10, 32'h34, 5'd0);
        after_edge();
        chk("full_ready", {31'd0, md_ready}, 32'd0);
        idle(5'd0);
        after_edge();
        chk("drain1_reg", {27'd0, ctrl_writeReg}, 32'd9);
        chk("drain1_data", data_writeReg, 32'h12);
        idle(5'd0);
        after_edge();
        chk("drain2_reg", {27'd0, ctrl_writeReg}, 32'd10);
        chk("drain2_data", data_writeReg, 32'h34);
        idle(5'd0);
        after_edge();
        chk("drain_done", {31'd0, ctrl_writeEnable}, 32'd0);

        // Starvation: reg 7 waits behind four pipeline writes.
        cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'h77, 5'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'(21 + i), 32'(i), 1'b0, 5'd0, 32'd0, 5'd0);
            after_edge();
            chk("starve_stall", {31'd0, wb_stall}, {31'd0, (i == 3)});
        end
        idle(5'd0);
        after_edge();
        chk("starve_clear", {31'd0, wb_stall}, 32'd0);
        chk("starve_pop_reg", {27'd0, ctrl_writeReg}, 32'd7);

        // Query probing while reg 12 waits, then until it commits.
        cycle(1'b1, 5'd21, 32'h0, 1'b1, 5'd12, 32'h55, 5'd0);
        cycle(1'b1, 5'd22, 32'h0, 1'b0, 5'd0, 32'd0, 5'd12);
        chk("q12", {31'd0, query_pending}, 32'd1);
        cycle(1'b1, 5'd23, 32'h0, 1'b0, 5'd0, 32'd0, 5'd13);
        chk("q13", {31'd0, query_pending}, 32'd0);
        cycle(1'b1, 5'd24, 32'h0, 1'b0, 5'd0, 32'd0, 5'd0);
        chk("q0", {31'd0, query_pending}, 32'd0);
        idle(5'd12);
        idle(5'd12);
        chk("q12_outstage", {31'd0, query_pending}, 32'd1);
        idle(5'd12);
        chk("q12_committed", {31'd0, query_pending}, 32'd0);

        // Full boundary: push refused while full even though a pop happens.
        cycle(1'b1, 5'd1, 32'h0, 1'b1, 5'd1, 32'hA1, 5'd0);
        cycle(1'b1, 5'd2, 32'h0, 1'b1, 5'd2, 32'hA2, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA3, 5'd0);
        chk("bound_refuse", {31'd0, md_ready}, 32'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA3, 5'd0);
        chk("bound_accept", {31'd0, md_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(11 + i), 32'hB0 + 32'(i), 5'd0);
        end
        repeat (4) idle(5'd0);

        // Reset mid-drain with two entries queued.
        cycle(1'b1, 5'd6, 32'h6, 1'b1, 5'd14, 32'hC4, 5'd15);
        cycle(1'b1, 5'd8, 32'h8, 1'b1, 5'd15, 32'hC5, 5'd15);
        idle(5'd15);
        @(posedge clock);
        #2;
        ctrl_reset = 1'b1;
        #1;
        chk("mid_rst_en", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("mid_rst_ready", {31'd0, md_ready}, 32'd1);
        chk("mid_rst_qp", {31'd0, query_pending}, 32'd0);
        model_reset();
        @(negedge clock);
        ctrl_reset = 1'b0;
        repeat (3) idle(5'd15);
        chk("mid_rst_nostale", {31'd0, ctrl_writeEnable}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic       wv;
            logic       mv;
            logic [4:0] wr;
            logic [4:0] mr;
            wv = ($urandom_range(0, 9) < 4);
            mv = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(wv, wr, $urandom, mv, mr, $urandom, 5'($urandom_range(0, 31)));
        end
        repeat (4) idle(5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_wb_write_arbiter
